instr_fetch_unit: RTL

Fetch stage directly upstream of the register file and ALU control. It holds the PC and requests instructions from instruction memory over a req/ready handshake. Each fetched word is presented to decode with a valid/ready handshake, together with its PC and PC+4. A redirect input applies taken-branch and jump targets; any in-flight or buffered wrong-path instruction is squashed.

---
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/instr_fetch_unit.sv | 93 +++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: the instruction-memory request channel, the decode delivery
// channel and the redirect input, bundled so the fetch unit has one bus port.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  logic        redirect;
  logic [31:0] redirect_pc;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4,
    input  imem_ready, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4,
    output imem_ready, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time over a
// req/ready handshake and hands it to decode; redirects squash wrong-path words.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic {
    FETCH = 1'b0,
    VALID = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_next_tgt_q;
  logic        kill_pending_q;
  logic        instr_valid_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic [31:0] pc_plus4_q;

  logic [31:0] redirect_tgt_d;
  logic [31:0] pc_seq_d;

  assign redirect_tgt_d = bus.redirect_pc & 32'hFFFF_FFFC;
  assign pc_seq_d       = pc_q + 32'd4;

  // The request drops in the reset cycle itself, not one cycle later.
  assign bus.imem_req    = (state_q == FETCH) && !reset;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc_plus4    = pc_plus4_q;

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= FETCH;
      pc_q           <= {RESET_PC[31:2], 2'b00};
      pc_next_tgt_q  <= 32'h0;
      kill_pending_q <= 1'b0;
      instr_valid_q  <= 1'b0;
      instr_q        <= 32'h0;
      instr_pc_q     <= 32'h0;
      pc_plus4_q     <= 32'h0;
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.imem_ready) begin
            if (bus.redirect) begin
              pc_q           <= redirect_tgt_d;
              kill_pending_q <= 1'b0;
            end else if (kill_pending_q) begin
              pc_q           <= pc_next_tgt_q;
              kill_pending_q <= 1'b0;
            end else begin
              instr_q       <= bus.imem_rdata;
              instr_pc_q    <= pc_q;
              pc_plus4_q    <= pc_seq_d;
              pc_q          <= pc_seq_d;
              instr_valid_q <= 1'b1;
              state_q       <= VALID;
            end
          end else if (bus.redirect) begin
            // Address must stay put until the memory accepts; park the target.
            pc_next_tgt_q  <= redirect_tgt_d;
            kill_pending_q <= 1'b1;
          end
        end

        VALID: begin
          if (bus.redirect) begin
            instr_valid_q <= 1'b0;
            pc_q          <= redirect_tgt_d;
            state_q       <= FETCH;
          end else if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= FETCH;
          end
        end

        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule
